// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium keystream engine.
//   - State/key/IV widths and the tap positions of the three shift registers
//     (1-based, in the cipher's own s1..s288 numbering).
//   - FSM state enum.
//   - trivium_load(): builds the 288-bit initial state from key and IV.
//   - trivium_update(): one state update, returning the next state and z.
// State vector layout: bit (n-1) holds cipher bit s<n>, so s1 is bit 0.
package trivium_pkg;

  localparam int STATE_W = 288;
  localparam int KEY_W   = 80;
  localparam int IV_W    = 80;

  // Register A (s1..s93)
  localparam int TAP_A_OUT  = 66;
  localparam int TAP_A_END  = 93;
  localparam int TAP_A_AND0 = 91;
  localparam int TAP_A_AND1 = 92;
  localparam int TAP_A_FB   = 171;
  // Register B (s94..s177)
  localparam int TAP_B_OUT  = 162;
  localparam int TAP_B_END  = 177;
  localparam int TAP_B_AND0 = 175;
  localparam int TAP_B_AND1 = 176;
  localparam int TAP_B_FB   = 264;
  // Register C (s178..s288)
  localparam int TAP_C_OUT  = 243;
  localparam int TAP_C_END  = 288;
  localparam int TAP_C_AND0 = 286;
  localparam int TAP_C_AND1 = 287;
  localparam int TAP_C_FB   = 69;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } fsm_e;

  typedef struct packed {
    logic [STATE_W-1:0] s;
    logic               z;
  } step_t;

  // Fetch cipher bit s<n> (1-based) from the packed state.
  function automatic logic tap(input logic [STATE_W-1:0] s, input int n);
    return s[n-1];
  endfunction

  // K1 is key[79], so the key lands bit-reversed in s1..s80; likewise IV in s94..s173.
  function automatic logic [STATE_W-1:0] trivium_load(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
    logic [STATE_W-1:0] s;
    s = '0;
    for (int i = 0; i < KEY_W; i++) s[i] = key[KEY_W-1-i];
    for (int i = 0; i < IV_W; i++) s[TAP_A_END+i] = iv[IV_W-1-i];
    s[STATE_W-1 -: 3] = 3'b111;
    return s;
  endfunction

  function automatic step_t trivium_update(input logic [STATE_W-1:0] s);
    step_t r;
    logic  t1, t2, t3;
    t1  = tap(s, TAP_A_OUT) ^ tap(s, TAP_A_END);
    t2  = tap(s, TAP_B_OUT) ^ tap(s, TAP_B_END);
    t3  = tap(s, TAP_C_OUT) ^ tap(s, TAP_C_END);
    r.z = t1 ^ t2 ^ t3;
    t1  = t1 ^ (tap(s, TAP_A_AND0) & tap(s, TAP_A_AND1)) ^ tap(s, TAP_A_FB);
    t2  = t2 ^ (tap(s, TAP_B_AND0) & tap(s, TAP_B_AND1)) ^ tap(s, TAP_B_FB);
    t3  = t3 ^ (tap(s, TAP_C_AND0) & tap(s, TAP_C_AND1)) ^ tap(s, TAP_C_FB);
    // Each register shifts toward higher indices; its feedback enters at its first bit.
    r.s = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    return r;
  endfunction

endpackage

// File: rtl/trivium_byte_packer.sv
// Packs keystream bits MSB-first into bytes behind a valid/ready output.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ena_i          global enable, low freezes all registers
//   clear_i        restart: drop partial byte and any pending output byte
//   bit_valid_i    a keystream bit is offered this cycle
//   bit_i          the offered keystream bit
//   bit_accept_o   the offered bit is taken (gates the cipher state update)
//   ks_valid_o     output byte available
//   ks_ready_i     consumer accepts the byte
//   ks_byte_o      output byte, bit 7 earliest
module trivium_byte_packer
  import trivium_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_i,
  input  logic       clear_i,
  input  logic       bit_valid_i,
  input  logic       bit_i,
  output logic       bit_accept_o,
  output logic       ks_valid_o,
  input  logic       ks_ready_i,
  output logic [7:0] ks_byte_o
);

  logic [7:0] asm_q, asm_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       last_bit;

  assign last_bit = (cnt_q == 3'd7);

  // The 8th bit may only be taken when the output register can receive it;
  // otherwise the whole cipher stalls so no bit is lost.
  assign bit_accept_o = bit_valid_i && !(last_bit && valid_q && !ks_ready_i);

  always_comb begin
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    if (clear_i) begin
      cnt_d   = 3'd0;
      valid_d = 1'b0;
    end else begin
      if (valid_q && ks_ready_i) valid_d = 1'b0;
      if (bit_accept_o) begin
        asm_d = {asm_q[6:0], bit_i};
        cnt_d = cnt_q + 3'd1;  // wraps 7 -> 0
        if (last_bit) begin
          byte_d  = {asm_q[6:0], bit_i};
          valid_d = 1'b1;      // overrides a same-cycle consume
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else if (ena_i) begin
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign ks_valid_o = valid_q;
  assign ks_byte_o  = byte_q;

endmodule

// File: rtl/trivium_keystream_core.sv
// Trivium keystream engine: loads key/IV on start, runs WARMUP_CYCLES blank
// updates, then emits keystream bytes on a valid/ready interface.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          global enable (low freezes everything)
//   start        load key/iv and begin warm-up (valid in any state)
//   key, iv      80-bit key and IV (bit 79 is K1 / IV1)
//   busy         warm-up in progress
//   ks_valid, ks_ready, ks_byte   keystream byte output handshake
module trivium_keystream_core
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = 1152,
  parameter int CNT_W         = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  output logic             busy,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [7:0]       ks_byte
);

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  step_t              upd;
  logic               bit_accept;

  assign upd = trivium_update(state_q);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (start) begin
      state_d = trivium_load(key, iv);
      wcnt_d  = '0;
      fsm_d   = WARMUP;
    end else begin
      case (fsm_q)
        WARMUP: begin
          state_d = upd.s;
          if (wcnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
            fsm_d  = RUN;
            wcnt_d = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        RUN: begin
          if (bit_accept) state_d = upd.s;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      wcnt_q  <= '0;
    end else if (ena) begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign busy = (fsm_q == WARMUP);

  trivium_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena_i        (ena),
    .clear_i      (start),
    .bit_valid_i  (fsm_q == RUN),
    .bit_i        (upd.z),
    .bit_accept_o (bit_accept),
    .ks_valid_o   (ks_valid),
    .ks_ready_i   (ks_ready),
    .ks_byte_o    (ks_byte)
  );

endmodule

// File: tb/tb_trivium_keystream_core.sv
module tb_trivium_keystream_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [79:0] key;
  logic [79:0] iv;
  logic        busy;
  logic        ks_valid;
  logic        ks_ready;
  logic [7:0]  ks_byte;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         ms[1:288];

  always #5 clk = ~clk;

  trivium_keystream_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .key      (key),
    .iv       (iv),
    .busy     (busy),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .ks_byte  (ks_byte)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the cipher state as a plain 1-based bit array s1..s288.
  task automatic model_bit(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
    ms[1] = t3;
    for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
    ms[178] = t2;
  endtask

  task automatic model_gen(input logic [79:0] k, input logic [79:0] v, input int n);
    bit z;
    logic [7:0] b;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = k[80-i];
      ms[93 + i] = v[80-i];
    end
    ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
    for (int i = 0; i < 4 * 288; i++) model_bit(z);
    exp_q.delete();
    for (int j = 0; j < n; j++) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        model_bit(z);
        b = {b[6:0], z};
      end
      exp_q.push_back(b);
    end
  endtask

  // Leaves the bench just after edge E0 (start sampled).
  task automatic start_stream(input logic [79:0] k, input logic [79:0] v);
    key   = k;
    iv    = v;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts edges after E0 until ks_valid; ena is held low for edges off_at+1..off_at+off_len.
  task automatic wait_valid(input int off_at, input int off_len,
                            output int first_edge, output int busy_fall);
    first_edge = -1;
    busy_fall  = -1;
    ks_ready   = 1'b1;
    for (int e = 1; e <= 3000; e++) begin
      ena = !(e > off_at && e <= off_at + off_len);
      step();
      if (busy_fall < 0 && !busy) busy_fall = e;
      if (ks_valid) begin
        first_edge = e;
        break;
      end
    end
    ena = 1'b1;
    if (first_edge < 0) check("valid_timeout", 32'(first_edge), 32'd0);
  endtask

  // Starts while ks_valid is high; gathers n bytes and compares them with exp_q.
  task automatic collect(input int n, input bit rnd, input bit chk_gap);
    int         cyc;
    bit         hold_chk;
    logic [7:0] held;
    cyc = 0;
    got_q.delete();
    while (got_q.size() < n && cyc < n * 40 + 100) begin
      ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ks_valid && ks_ready) begin
        if (chk_gap) check("byte_period", 32'(cyc), 32'(8 * got_q.size()));
        got_q.push_back(ks_byte);
      end
      hold_chk = ks_valid && !ks_ready;
      held     = ks_byte;
      step();
      cyc++;
      if (hold_chk) begin
        check("hold_valid", 32'(ks_valid), 32'd1);
        check("hold_byte", 32'(ks_byte), 32'(held));
      end
    end
    if (got_q.size() < n) check("collect_timeout", 32'(got_q.size()), 32'(n));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    $display("stream: %0d bytes collected in %0d cycles, first %02h", got_q.size(), cyc,
             (got_q.size() > 0) ? got_q[0] : 8'h00);
  endtask

  initial begin
    int         fe, bf;
    logic [79:0] k, v;
    logic [7:0]  held;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; key = '0; iv = '0; ks_ready = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(ks_valid), 32'd0);
    check("rst_byte", 32'(ks_byte), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Warm-up timing with all-zero key/IV.
    model_gen('0, '0, 16);
    start_stream('0, '0);
    check("busy_after_e0", 32'(busy), 32'd1);
    wait_valid(0, 0, fe, bf);
    check("busy_fall_edge", 32'(bf), 32'd1152);
    check("first_valid_edge", 32'(fe), 32'd1160);
    collect(16, 1'b0, 1'b1);

    // Known-answer vector, always ready.
    k = 80'h0123456789ABCDEF0123;
    v = 80'hFEDCBA98765432100011;
    model_gen(k, v, 64);
    start_stream(k, v);
    wait_valid(0, 0, fe, bf);
    check("kat_first_valid", 32'(fe), 32'd1160);
    collect(64, 1'b0, 1'b1);

    // Random key/IV with random backpressure.
    k = {$urandom(), $urandom(), 16'($urandom())};
    v = {$urandom(), $urandom(), 16'($urandom())};
    model_gen(k, v, 32);
    start_stream(k, v);
    wait_valid(0, 0, fe, bf);
    collect(32, 1'b1, 1'b0);

    // Long stall right after the first byte, then drain.
    k = {$urandom(), $urandom(), 16'($urandom())};
    v = {$urandom(), $urandom(), 16'($urandom())};
    model_gen(k, v, 24);
    start_stream(k, v);
    wait_valid(0, 0, fe, bf);
    ks_ready = 1'b0;
    held = ks_byte;
    for (int i = 0; i < 40; i++) begin
      step();
      check("stall_byte", 32'(ks_byte), 32'(held));
      check("stall_busy", 32'(busy), 32'd0);
      check("stall_valid", 32'(ks_valid), 32'd1);
    end
    collect(24, 1'b0, 1'b0);

    // Restart with a byte pending, then an enable gap during warm-up.
    ks_ready = 1'b0;
    for (int i = 0; i < 20 && !ks_valid; i++) step();
    check("pending_valid", 32'(ks_valid), 32'd1);
    v = {$urandom(), $urandom(), 16'($urandom())};
    model_gen(k, v, 16);
    start_stream(k, v);
    check("restart_valid", 32'(ks_valid), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    wait_valid(500, 100, fe, bf);
    check("ena_gap_first_valid", 32'(fe), 32'd1260);
    collect(16, 1'b1, 1'b0);

    // Asynchronous reset while a byte is pending.
    ks_ready = 1'b0;
    for (int i = 0; i < 20 && !ks_valid; i++) step();
    check("prereset_valid", 32'(ks_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_valid", 32'(ks_valid), 32'd0);
    check("async_rst_byte", 32'(ks_byte), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ks_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ks_valid || busy) begin
        check("post_rst_quiet", {30'd0, busy, ks_valid}, 32'd0);
        break;
      end
    end
    check("post_rst_valid", 32'(ks_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trivium_keystream_core.md
Name: trivium_keystream_core

Overview:
- Trivium stream-cipher engine feeding the byte-wide keystream output path of the tt_um top level.
- Takes the 80-bit key and 80-bit IV presented on the top-level extra IO and loads the 288-bit state.
- Runs the 1152-round warm-up, then produces keystream one bit per cycle.
- Packs the keystream MSB-first into bytes on a valid/ready interface.

Parameters:
- WARMUP_CYCLES, 1152, number of blank state updates after load (4 x 288).
- CNT_W, 11, width of the warm-up counter; must hold WARMUP_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state, including the FSM, counters, cipher state and output register.
- start  in  1  single-cycle pulse; loads key/iv and begins warm-up.
- key  in  80  cipher key; key[79] is K1, key[0] is K80.
- iv  in  80  initialisation vector; iv[79] is IV1, iv[0] is IV80.
- busy  out  1  high while warm-up is in progress.
- ks_valid  out  1  output byte available.
- ks_ready  in  1  consumer accepts the byte when ks_valid and ks_ready are both high.
- ks_byte  out  8  keystream byte; bit 7 is the earliest generated keystream bit.

Behaviour:
- Reset (asynchronous, rst_n low): FSM=IDLE; state=0; busy=0; ks_valid=0; ks_byte=0; bit counter=0; warm-up counter=0.
- All sequential updates are qualified by ena=1.
- Load, on a clock edge with start=1, in any FSM state:
  - s1..s93 = K1..K80 followed by 13 zeros.
  - s94..s177 = IV1..IV80 followed by 4 zeros.
  - s178..s288 = 108 zeros followed by 1,1,1.
  - Warm-up counter cleared; bit counter cleared; ks_valid cleared; FSM moves to WARMUP.
  - start during RUN or WARMUP aborts the current stream and any pending byte is discarded.
- Update function, per state-update cycle:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3.
  - t1 ^= (s91&s92)^s171; t2 ^= (s175&s176)^s264; t3 ^= (s286&s287)^s69.
  - s1..s93 <= t3,s1..s92; s94..s177 <= t1,s94..s176; s178..s288 <= t2,s178..s287.
- IDLE: no state update; busy=0.
- WARMUP: one update per cycle with z discarded; busy=1.
  - After the WARMUP_CYCLES-th update, FSM moves to RUN and busy falls on the same edge.
- RUN: one update per cycle; z is shifted into an 8-bit assembly register, MSB first.
  - On the 8th bit the assembled byte transfers to ks_byte and ks_valid=1, provided the output register is empty or being consumed in that same cycle.
  - Stall: when the bit counter equals 7, the output register is full and ks_ready=0, no state update occurs and the assembly register holds. No keystream bit is ever dropped or duplicated.
  - Simultaneous consume and transfer: ks_valid stays 1 and ks_byte takes the new byte.
  - Consume without a new byte: ks_valid goes to 0 on the next edge.
- Latency: with start sampled at edge E0, warm-up updates occur at E1..E1152.
  - First byte assembled at E1153..E1160; ks_valid is first high after E1160.
  - With ks_ready held high, ks_valid pulses for 1 cycle every 8 cycles thereafter.
- ks_byte is stable while ks_valid=1 and ks_ready=0.
- No combinational path from ks_ready to ks_valid or ks_byte.

Decomposition:
- Package trivium_pkg holds:
  - STATE_W=288, KEY_W=80, IV_W=80;
  - tap index constants (66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69);
  - FSM enum {IDLE, WARMUP, RUN};
  - a function computing next-state and z from the current state.
- Sub-module trivium_byte_packer: 8-bit assembly register, bit counter, output register and valid/ready/stall logic. It exports a "bit_accept" signal that gates state updates in RUN.

Test Plan:
- Reset: assert rst_n=0 mid-RUN with ks_valid=1 → busy=0, ks_valid=0 and ks_byte=0 immediately (asynchronous); no activity until the next start.
- Warm-up timing: key=0, iv=0, start at E0, ks_ready=1 → busy high E0..E1151, low after E1152; ks_valid first high after E1160.
- Known-answer: key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA98765432100011, ks_ready=1 → first 64 bytes match the bench's bit-level reference model of the update equations above; z bit 1 appears at ks_byte[7] of byte 0.
- Backpressure: hold ks_ready=0 for 40 cycles after the first ks_valid → ks_byte unchanged and busy=0 throughout. After release, the byte stream equals the no-stall stream byte-for-byte.
- Restart and enable: pulse start in RUN with a new IV → pending byte dropped and ks_valid=0 next cycle. Drop ena for 100 cycles during WARMUP → first ks_valid arrives exactly 100 cycles later than nominal.
